// File: rtl/axis_frame_validator.sv
// axis_frame_validator: per-frame beat counter and length policer in front of the frame FIFO.
// Latency: 1 cycle input to output through one register; status pulses 1 cycle after tlast is accepted.
// Backpressure: input_axis_tready = output_axis_tready | ~output_axis_tvalid; forced to 1 while a truncated tail is dropped.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   input_axis_*                    upstream AXI-stream (tuser = upstream error, any beat)
//   output_axis_*                   downstream AXI-stream (tuser = bad-frame mark, last beat only)
//   length_min / length_max         runtime limits, sampled on the first beat of each frame
//   frame_done                      one-cycle pulse per completed input frame
//   frame_bad / err_runt / err_oversize / frame_len
//                                   per-frame status, valid only with frame_done
module axis_frame_validator #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,

  output logic                  frame_done,
  output logic                  frame_bad,
  output logic                  err_runt,
  output logic                  err_oversize,
  output logic [LEN_WIDTH-1:0]  frame_len
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_TRUNC = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] CNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // Frame tracking state
  state_t                state_q,    state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  err_q,      err_d;
  logic [LEN_WIDTH-1:0]  len_min_q,  len_min_d;
  logic [LEN_WIDTH-1:0]  len_max_q,  len_max_d;

  // Output register
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_vld_q,  out_vld_d;
  logic                  out_last_q, out_last_d;
  logic                  out_user_q, out_user_d;

  // Status registers
  logic                  done_q,     done_d;
  logic                  bad_q,      bad_d;
  logic                  runt_q,     runt_d;
  logic                  over_q,     over_d;
  logic [LEN_WIDTH-1:0]  flen_q,     flen_d;

  // Per-beat decode
  logic                  in_rdy;
  logic                  in_fire;
  logic                  frame_start;
  logic [LEN_WIDTH-1:0]  cnt_cur;
  logic [LEN_WIDTH-1:0]  lim_min;
  logic [LEN_WIDTH-1:0]  lim_max;
  logic                  err_cur;
  logic                  is_runt;
  logic                  is_oversize;

  // While dropping a truncated tail the output register is not written,
  // so the input never has to wait for the downstream.
  assign in_rdy  = (state_q == ST_TRUNC) | output_axis_tready | ~out_vld_q;
  assign in_fire = input_axis_tvalid & in_rdy;

  // In IDLE the beat being offered is the first of a new frame: its index is 1,
  // the limits come straight from the ports and no earlier error can apply.
  assign frame_start = (state_q == ST_IDLE);
  assign cnt_cur     = frame_start          ? CNT_ONE :
                       (beat_cnt_q == CNT_MAX) ? beat_cnt_q : (beat_cnt_q + CNT_ONE);
  assign lim_min     = frame_start ? length_min : len_min_q;
  assign lim_max     = frame_start ? length_max : len_max_q;
  assign err_cur     = (frame_start ? 1'b0 : err_q) | input_axis_tuser;
  assign is_runt     = (cnt_cur < lim_min);
  // A frame of exactly lim_max beats that ends on that beat is legal, so only
  // a non-last beat at the limit triggers truncation.
  assign is_oversize = (lim_max != '0) && (cnt_cur == lim_max) && !input_axis_tlast;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    len_min_d  = len_min_q;
    len_max_d  = len_max_q;

    out_data_d = out_data_q;
    out_vld_d  = out_vld_q & ~output_axis_tready;
    out_last_d = out_last_q;
    out_user_d = out_user_q;

    done_d     = 1'b0;
    bad_d      = 1'b0;
    runt_d     = 1'b0;
    over_d     = 1'b0;
    flen_d     = '0;

    if (in_fire) begin
      beat_cnt_d = cnt_cur;
      if (state_q == ST_TRUNC) begin
        // Tail of an oversize frame: consumed, never forwarded.
        if (input_axis_tlast) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          done_d  = 1'b1;
          bad_d   = 1'b1;
          over_d  = 1'b1;
          flen_d  = cnt_cur;
        end
      end else begin
        len_min_d  = lim_min;
        len_max_d  = lim_max;
        err_d      = err_cur;
        out_vld_d  = 1'b1;
        out_data_d = input_axis_tdata;
        if (is_oversize) begin
          // Close the frame early and mark it bad; the FIFO drops it.
          out_last_d = 1'b1;
          out_user_d = 1'b1;
          state_d    = ST_TRUNC;
        end else if (input_axis_tlast) begin
          out_last_d = 1'b1;
          out_user_d = err_cur | is_runt;
          state_d    = ST_IDLE;
          err_d      = 1'b0;
          done_d     = 1'b1;
          bad_d      = err_cur | is_runt;
          runt_d     = is_runt;
          flen_d     = cnt_cur;
        end else begin
          out_last_d = 1'b0;
          out_user_d = 1'b0;
          state_d    = ST_PASS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      len_min_q  <= '0;
      len_max_q  <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      runt_q     <= 1'b0;
      over_q     <= 1'b0;
      flen_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      len_min_q  <= len_min_d;
      len_max_q  <= len_max_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      runt_q     <= runt_d;
      over_q     <= over_d;
      flen_q     <= flen_d;
    end
  end

  assign input_axis_tready  = in_rdy;
  assign output_axis_tdata  = out_data_q;
  assign output_axis_tvalid = out_vld_q;
  assign output_axis_tlast  = out_last_q;
  assign output_axis_tuser  = out_user_q;
  assign frame_done         = done_q;
  assign frame_bad          = bad_q;
  assign err_runt           = runt_q;
  assign err_oversize       = over_q;
  assign frame_len          = flen_q;

endmodule

// File: tb/tb_axis_frame_validator.sv
// tb_axis_frame_validator: directed and randomized frames against a frame-level
//   reference model (expected output beats and status per frame).
// A narrow LEN_WIDTH keeps beat-counter saturation reachable in a short run.
module tb_axis_frame_validator;

  localparam int DW  = 8;
  localparam int LW  = 4;
  localparam int SAT = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_vld, in_rdy, in_last, in_user;
  logic [DW-1:0] out_data;
  logic          out_vld, out_rdy, out_last, out_user;
  logic [LW-1:0] length_min, length_max;
  logic          frame_done, frame_bad, err_runt, err_oversize;
  logic [LW-1:0] frame_len;

  always #5 clk = ~clk;

  axis_frame_validator #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .input_axis_tdata  (in_data),
    .input_axis_tvalid (in_vld),
    .input_axis_tready (in_rdy),
    .input_axis_tlast  (in_last),
    .input_axis_tuser  (in_user),
    .output_axis_tdata (out_data),
    .output_axis_tvalid(out_vld),
    .output_axis_tready(out_rdy),
    .output_axis_tlast (out_last),
    .output_axis_tuser (out_user),
    .length_min        (length_min),
    .length_max        (length_max),
    .frame_done        (frame_done),
    .frame_bad         (frame_bad),
    .err_runt          (err_runt),
    .err_oversize      (err_oversize),
    .frame_len         (frame_len)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic          bad;
    logic          runt;
    logic          over;
    logic [LW-1:0] len;
  } stat_t;

  beat_t exp_b[$], obs_b[$];
  stat_t exp_s[$], obs_s[$];
  int    in_cyc[$], out_cyc[$], done_cyc[$];
  int    cyc = 0;
  int    viol = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    rdy_mode = 0;
  int    ph = 0;
  logic  prev_stall;
  beat_t prev_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random, 3 = never
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
        2:       out_rdy = 1'($urandom_range(1, 0));
        default: out_rdy = 1'b0;
      endcase
      ph++;
    end
  end

  // Monitor: collects transfers and status pulses, counts protocol violations
  initial begin
    prev_stall = 1'b0;
    prev_b     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(out_vld === 1'b1 && {out_data, out_last, out_user} === prev_b)) viol++;
        if (out_vld && out_user && !out_last) viol++;
        if (out_vld && out_rdy) begin
          obs_b.push_back({out_data, out_last, out_user});
          out_cyc.push_back(cyc);
        end
        prev_stall = out_vld && !out_rdy;
        prev_b     = {out_data, out_last, out_user};
        if (in_vld && in_rdy) in_cyc.push_back(cyc);
        if (frame_done) begin
          obs_s.push_back({frame_bad, err_runt, err_oversize, frame_len});
          done_cyc.push_back(cyc);
        end else if (frame_bad || err_runt || err_oversize || frame_len != '0) begin
          viol++;
        end
      end
    end
  end

  task automatic clear_q();
    exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
    in_cyc.delete(); out_cyc.delete(); done_cyc.delete();
    viol = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic u);
    int   t = 0;
    logic acc = 1'b0;
    in_data = d; in_last = l; in_user = u; in_vld = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    in_vld = 1'b0;
  endtask

  // Reference model: frame-level outcome from the length/error rules.
  task automatic send_frame(input int len, input int lmin, input int lmax, input logic [31:0] emask,
                            input int gap, input int dbase, input int dstep);
    logic over, anyerr, rnt;
    int   nout;
    beat_t b;
    stat_t s;
    over   = (lmax != 0) && (len > lmax);
    nout   = over ? lmax : len;
    anyerr = 1'b0;
    for (int i = 0; i < len && i < 32; i++) if (emask[i]) anyerr = 1'b1;
    rnt    = (len < lmin);
    for (int i = 0; i < nout; i++) begin
      b.data = DW'(dbase + i * dstep);
      b.last = (i == nout - 1);
      b.user = (i == nout - 1) ? (over | anyerr | rnt) : 1'b0;
      exp_b.push_back(b);
    end
    s.bad  = over | anyerr | rnt;
    s.runt = over ? 1'b0 : rnt;
    s.over = over;
    s.len  = LW'((len > SAT) ? SAT : len);
    exp_s.push_back(s);
    for (int i = 0; i < len; i++) begin
      if (gap > 0) repeat ($urandom_range(gap, 0)) begin @(posedge clk); #1; end
      if (i == 0) begin
        length_min = LW'(lmin);
        length_max = LW'(lmax);
      end
      send_beat(DW'(dbase + i * dstep), (i == len - 1), (i < 32) ? emask[i] : 1'b0);
      if (i == 0) begin
        // Limits must be ignored after the first beat.
        length_min = LW'($urandom);
        length_max = LW'($urandom);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((obs_b.size() < exp_b.size() || obs_s.size() < exp_s.size()) && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_all(input string tag);
    drain();
    check($sformatf("%s:beat_count", tag), 32'(obs_b.size()), 32'(exp_b.size()));
    check($sformatf("%s:stat_count", tag), 32'(obs_s.size()), 32'(exp_s.size()));
    for (int i = 0; i < exp_b.size(); i++)
      if (i < obs_b.size()) check($sformatf("%s:beat%0d{data,last,user}", tag, i), 32'(obs_b[i]), 32'(exp_b[i]));
    for (int i = 0; i < exp_s.size(); i++)
      if (i < obs_s.size()) check($sformatf("%s:stat%0d{bad,runt,over,len}", tag, i), 32'(obs_s[i]), 32'(exp_s[i]));
    check($sformatf("%s:protocol_violations", tag), 32'(viol), 32'd0);
    clear_q();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_last = 1'b0; in_user = 1'b0;
    length_min = '0; length_max = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:tvalid",       32'(out_vld),      32'd0);
    check("rst:tdata",        32'(out_data),     32'd0);
    check("rst:tlast",        32'(out_last),     32'd0);
    check("rst:tuser",        32'(out_user),     32'd0);
    check("rst:frame_done",   32'(frame_done),   32'd0);
    check("rst:frame_bad",    32'(frame_bad),    32'd0);
    check("rst:err_runt",     32'(err_runt),     32'd0);
    check("rst:err_oversize", 32'(err_oversize), 32'd0);
    check("rst:frame_len",    32'(frame_len),    32'd0);
    check("rst:tready",       32'(in_rdy),       32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();

    // Good frame, with latency and throughput checks
    rdy_mode = 0;
    send_frame(3, 2, 4, 32'h0, 0, 'h11, 'h11);
    drain();
    if (in_cyc.size() >= 3 && out_cyc.size() >= 3 && done_cyc.size() >= 1) begin
      for (int i = 0; i < 3; i++) check($sformatf("good:latency%0d", i), 32'(out_cyc[i] - in_cyc[i]), 32'd1);
      check("good:status_latency", 32'(done_cyc[0] - in_cyc[2]), 32'd1);
      check("good:throughput",     32'(in_cyc[2] - in_cyc[0]),   32'd2);
    end
    check_all("good");

    send_frame(6, 0, 4, 32'h0, 0, 'hA0, 1);      check_all("oversize");
    send_frame(1, 4, 0, 32'h0, 0, 'h5A, 0);      check_all("runt");
    send_frame(4, 2, 8, 32'h2, 0, 'hC0, 1);      check_all("upstream_err");

    rdy_mode = 1;
    send_frame(5, 0, 0, 32'h0, 0, 'h30, 3);      check_all("backpressure");
    rdy_mode = 0;

    send_frame(4, 0, 4, 32'h0, 0, 'h40, 1);      check_all("exact_max");
    send_frame(3, 3, 0, 32'h0, 0, 'h48, 1);      check_all("exact_min");
    send_frame(1, 1, 0, 32'h0, 0, 'h4F, 0);      check_all("min1_single");
    send_frame(1, 0, 1, 32'h0, 0, 'h50, 0);      check_all("max1_single");
    send_frame(2, 0, 1, 32'h0, 0, 'h52, 1);      check_all("max1_two");

    // Back-to-back frames with no idle cycle
    send_frame(2, 0, 0, 32'h0, 0, 'h60, 1);
    send_frame(3, 2, 0, 32'h0, 0, 'h62, 1);
    send_frame(1, 0, 0, 32'h1, 0, 'h65, 1);
    drain();
    if (in_cyc.size() >= 6) check("b2b:no_idle", 32'(in_cyc[5] - in_cyc[0]), 32'd5);
    check_all("back_to_back");

    // Tail of an oversize frame is accepted even with the output stalled
    rdy_mode = 3;
    send_frame(4, 0, 1, 32'h0, 0, 'h70, 1);
    rdy_mode = 0;
    check_all("trunc_stalled");

    // Counter saturation
    send_frame(20, 0, 0,  32'h0, 0, 'h80, 1);    check_all("sat_nolimit");
    send_frame(18, 0, SAT, 32'h0, 0, 'h90, 1);   check_all("sat_trunc");
    send_frame(SAT, 0, SAT, 32'h0, 0, 'h20, 1);  check_all("sat_exact");

    // Reset in the middle of a frame
    length_min = '0; length_max = '0;
    send_beat(8'h91, 1'b0, 1'b0);
    send_beat(8'h92, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid:tvalid",     32'(out_vld),    32'd0);
    check("rst_mid:tdata",      32'(out_data),   32'd0);
    check("rst_mid:frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_frame(2, 0, 0, 32'h0, 0, 'hB1, 1);      check_all("post_reset");

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int          len, lmin, lmax;
      logic [31:0] em;
      len  = int'($urandom_range(20, 1));
      lmin = int'($urandom_range(6, 0));
      lmax = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      em   = ($urandom_range(3, 0) == 0) ? (32'h1 << $urandom_range(19, 0)) : 32'h0;
      rdy_mode = int'($urandom_range(2, 0));
      send_frame(len, lmin, lmax, em, 2, int'($urandom_range(255, 0)), int'($urandom_range(7, 1)));
      rdy_mode = 0;
      check_all($sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_validator.md
# axis_frame_validator

Stream stage placed directly upstream of the frame FIFO. It counts beats per AXI-stream frame and enforces a runtime minimum and maximum frame length. Oversize frames are truncated and marked bad; runt frames and frames with an upstream error are also marked bad. The bad mark is `tuser` on the last beat, which the frame FIFO uses to discard the whole frame. One registered output stage; per-frame status pulses for counters and debug.

## Interface
- `DATA_WIDTH`, 8: data beat width.
- `LEN_WIDTH`, 16: width of the beat counter and of the length limits.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `input_axis_tdata`  in  DATA_WIDTH  input beat data.
- `input_axis_tvalid`  in  1  input beat valid.
- `input_axis_tready`  out  1  input beat accept.
- `input_axis_tlast`  in  1  last beat of the frame.
- `input_axis_tuser`  in  1  upstream error flag; may be asserted on any beat.
- `output_axis_tdata`  out  DATA_WIDTH  output beat data.
- `output_axis_tvalid`  out  1  output beat valid.
- `output_axis_tready`  in  1  downstream accept.
- `output_axis_tlast`  out  1  last beat of the frame; forced to 1 on a truncated beat.
- `output_axis_tuser`  out  1  bad-frame mark; only ever 1 on a `tlast` beat.
- `length_min`  in  LEN_WIDTH  minimum legal beats per frame. 0 or 1 means no runt check.
- `length_max`  in  LEN_WIDTH  maximum legal beats per frame. 0 means no limit.
- `frame_done`  out  1  one-cycle pulse when the last input beat of a frame is accepted.
- `frame_bad`  out  1  valid with `frame_done`; frame was marked bad.
- `err_runt`  out  1  valid with `frame_done`; frame was shorter than `length_min`.
- `err_oversize`  out  1  valid with `frame_done`; frame exceeded `length_max` and was truncated.
- `frame_len`  out  LEN_WIDTH  valid with `frame_done`; beats received at the input, saturating at all-ones.

## Operation
- The state machine has three states: IDLE, PASS and TRUNC.
- **Limits:** `length_min` and `length_max` are sampled on the first accepted beat of each frame and held until that frame ends. Changes mid-frame have no effect.
- **Beat count:** `beat_cnt` is the 1-based index of the current beat. It is 1 on the first beat and saturates at 2^LEN_WIDTH−1.
- **IDLE:**
  - On an accepted beat, sample the limits and set `beat_cnt` to 1.
  - Evaluate the beat with the beat rules below.
  - If it is the last beat, stay in IDLE; otherwise go to PASS or TRUNC.
- **PASS:** evaluate each accepted beat with the beat rules below.
- **Beat rules (IDLE and PASS):**
  - Sticky error `err_s` becomes `err_s | input_axis_tuser`.
  - Oversize: `length_max` ≠ 0, `beat_cnt` == `length_max`, and `tlast` = 0.
    - Forward the beat with `tlast` = 1 and `tuser` = 1.
    - Go to TRUNC.
  - Input `tlast` = 1:
    - Forward the beat with `tuser = err_s_next | runt`, where `runt = (beat_cnt < length_min)`.
    - Pulse the status outputs.
    - Go to IDLE.
  - Otherwise forward the beat with `tuser` = 0.
- **TRUNC:**
  - `input_axis_tready` = 1 regardless of output state.
  - Beats are consumed and discarded; `beat_cnt` keeps counting.
  - On `tlast`: pulse `frame_done` with `frame_bad` = 1, `err_oversize` = 1 and `err_runt` = 0, then go to IDLE.
- **Status:** all status outputs are registered and pulse in the cycle after the input `tlast` acceptance. `frame_bad`, `err_runt`, `err_oversize` and `frame_len` are 0 whenever `frame_done` = 0.
- **Exact length:** a frame of exactly `length_max` beats ending in `tlast` is good.
- **Saturation:** once `beat_cnt` saturates, it holds at the maximum value.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - State goes to IDLE; `beat_cnt`, `err_s` and the sampled limits clear.
  - All outputs read 0: `output_axis_tvalid`, `output_axis_tdata`, `output_axis_tlast`, `output_axis_tuser` and every status output.
  - A frame in flight is abandoned. The next accepted beat starts a new frame.
- **Output register:** single stage.
  - `input_axis_tready = output_axis_tready | ~output_axis_tvalid` in IDLE and PASS.
  - Latency from an input transfer to the output beat is 1 cycle.
  - Full throughput of 1 beat per cycle under continuous ready.
- **Handshake:** the output beat holds stable while `output_axis_tvalid` = 1 and `output_axis_tready` = 0. `output_axis_tvalid` never drops without a transfer.
- **Transition into TRUNC:** the truncated beat occupies the output register. Subsequent discarded beats do not touch the output register.
- **Back-to-back frames:** supported with no idle cycle. A frame ending in cycle N and the next frame's first beat in cycle N+1 are both processed normally.
- **Single-beat frame:** `beat_cnt` is 1 on that beat. It is a runt iff `length_min` > 1.

## Test plan
- **Good frame:** `length_min` = 2, `length_max` = 4, 3-beat frame 0x11, 0x22, 0x33 with `tlast` on 0x33, ready held 1.
  - Outputs appear 1 cycle later, identical, with `tuser` = 0.
  - `frame_done` pulses with `frame_len` = 3 and `frame_bad` = 0.
- **Oversize:** `length_max` = 4, 6-beat frame 0xA0..0xA5.
  - Output is 0xA0..0xA3, with beat 0xA3 carrying `tlast` = 1 and `tuser` = 1.
  - 0xA4 and 0xA5 are accepted and dropped.
  - `frame_done` pulses with `err_oversize` = 1 and `frame_len` = 6.
- **Runt:** `length_min` = 4, single-beat frame 0x5A with `tlast`.
  - Output is 0x5A with `tlast` = 1 and `tuser` = 1.
  - Status shows `err_runt` = 1 and `frame_len` = 1.
- **Upstream error:** 4-beat frame with input `tuser` = 1 on beat 2 only.
  - Beats 1–3 output `tuser` = 0; beat 4 (last) outputs `tuser` = 1.
  - Status shows `frame_bad` = 1, `err_runt` = 0 and `err_oversize` = 0.
- **Backpressure:** ready toggled 1,0,0,1,… during a 5-beat frame.
  - Output data and `tlast` are stable across stalls.
  - No beat is lost or duplicated, and the sequence is preserved.
- **Reset mid-frame:** `rst_n` low after beat 2 of a 4-beat frame.
  - `output_axis_tvalid` goes to 0 immediately.
  - After release, a new 2-beat frame passes with `frame_len` = 2 and `frame_bad` = 0.
